// File: rtl/bm_slave_port.sv
// AHB-Lite responder port of the bus matrix: decodes haddr[31:28] to a target and holds each transfer
// until that target grants and completes it. Define BM_DECODE_ERR_EN to answer unmapped addresses with ERROR.
module bm_slave_port #(
    parameter int NUM_TARGETS = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              hclk,
    input  logic                              hreset,
    input  logic                              hsel,
    input  logic [31:0]                       haddr,
    input  logic [1:0]                        htrans,
    input  logic                              hwrite,
    input  logic [2:0]                        hsize,
    input  logic [2:0]                        hburst,
    input  logic [3:0]                        hprot,
    input  logic                              hready,
    input  logic [DATA_WIDTH-1:0]             hwdata,
    output logic                              hreadyout,
    output logic [1:0]                        hresp,
    output logic [DATA_WIDTH-1:0]             hrdata,
    output logic [NUM_TARGETS-1:0]            req,
    output logic [31:0]                       t_haddr,
    output logic [1:0]                        t_htrans,
    output logic                              t_hwrite,
    output logic [2:0]                        t_hsize,
    output logic [2:0]                        t_hburst,
    output logic [3:0]                        t_hprot,
    output logic                              t_hready,
    output logic [DATA_WIDTH-1:0]             t_hwdata,
    input  logic [NUM_TARGETS-1:0]            gnt,
    input  logic [NUM_TARGETS-1:0]            t_hreadyout,
    input  logic [2*NUM_TARGETS-1:0]          t_hresp,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] t_hrdata
);
    localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_capture;

    logic [31:0]             r_haddr;
    logic [1:0]              r_htrans;
    logic                    r_hwrite;
    logic [2:0]              r_hsize;
    logic [2:0]              r_hburst;
    logic [3:0]              r_hprot;
    logic [TW-1:0]           r_tgt;

    logic                    w_accept;
    logic                    w_mapped;
    logic [31:0]             w_tgt_ofs;
    logic                    w_sel_ready;
    logic [1:0]              w_sel_resp;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;
    logic [NUM_TARGETS-1:0]  w_req_onehot;

    assign w_accept    = hsel && hready && htrans[1];
    assign w_mapped    = ({28'd0, haddr[31:28]} < 32'(NUM_TARGETS));
    assign w_tgt_ofs   = 32'(r_tgt);
    assign w_sel_ready = t_hreadyout[r_tgt];
    assign w_sel_resp  = t_hresp[2*w_tgt_ofs +: 2];
    assign w_sel_rdata = t_hrdata[DATA_WIDTH*w_tgt_ofs +: DATA_WIDTH];

    always_comb begin
        w_req_onehot        = '0;
        w_req_onehot[r_tgt] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Only an address phase the port can actually take this cycle is captured.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        unique case (r_state)
            ST_IDLE: w_capture = w_accept;
            ST_PEND: begin
                if (gnt[r_tgt] && w_sel_ready) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_sel_ready) begin
                    w_capture    = w_accept;
                    w_next_state = ST_IDLE;
                end
            end
`ifdef BM_DECODE_ERR_EN
            ST_ERR1: w_next_state = ST_ERR2;
            ST_ERR2: begin
                w_capture    = w_accept;
                w_next_state = ST_IDLE;
            end
`endif
            default: w_next_state = ST_IDLE;
        endcase
        if (w_capture) begin
`ifdef BM_DECODE_ERR_EN
            w_next_state = w_mapped ? ST_PEND : ST_ERR1;
`else
            w_next_state = w_mapped ? ST_PEND : ST_IDLE;
`endif
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_haddr  <= '0;
            r_htrans <= '0;
            r_hwrite <= 1'b0;
            r_hsize  <= '0;
            r_hburst <= '0;
            r_hprot  <= '0;
            r_tgt    <= '0;
        end else if (w_capture) begin
            r_haddr  <= haddr;
            r_htrans <= htrans;
            r_hwrite <= hwrite;
            r_hsize  <= hsize;
            r_hburst <= hburst;
            r_hprot  <= hprot;
            r_tgt    <= haddr[28 +: TW];
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 2'b00;
        hrdata    = '0;
        req       = '0;
        t_htrans  = 2'b00;
        t_hready  = 1'b1;
        unique case (r_state)
            ST_PEND: begin
                hreadyout = 1'b0;
                req       = w_req_onehot;
                t_htrans  = r_htrans;
            end
            ST_DATA: begin
                hreadyout = w_sel_ready;
                hresp     = w_sel_resp;
                hrdata    = w_sel_rdata;
                t_hready  = w_sel_ready;
            end
`ifdef BM_DECODE_ERR_EN
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 2'b01;
            end
            ST_ERR2: hresp = 2'b01;
`endif
            default: ;
        endcase
    end

    assign t_haddr  = r_haddr;
    assign t_hwrite = r_hwrite;
    assign t_hsize  = r_hsize;
    assign t_hburst = r_hburst;
    assign t_hprot  = r_hprot;
    assign t_hwdata = hwdata;

endmodule
